// File: rtl/ucsbece154b_bp_pkg.sv
// Shared definitions for the gshare branch predictor.
//   OP_BRANCH / OP_JAL : opcode values that are eligible for prediction
//   ctr_t              : 2-bit saturating direction counter encodings
//   btb_entry_t        : one BTB line (tag sized for the smallest legal BTB)
//   ctr_next           : saturating counter update
package ucsbece154b_bp_pkg;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   // Tag is pc[31:BI+2]; with the smallest BTB (BI=2) that is 28 bits.
   // Narrower configurations zero-extend, so the top bits fold away.
   localparam int TAG_MAX = 28;

   typedef struct packed {
      logic               valid;
      logic               jump;
      logic [TAG_MAX-1:0] tag;
      logic [31:0]        target;
   } btb_entry_t;

   function automatic ctr_t ctr_next(ctr_t c, logic taken);
      ctr_t n;
      n = c;
      if (taken && (c != ST))
         n = ctr_t'(c + 2'd1);
      else if (!taken && (c != SNT))
         n = ctr_t'(c - 2'd1);
      return n;
   endfunction

endpackage

// File: rtl/ucsbece154b_btb.sv
// Direct-mapped, tagged branch target buffer with one combinational read
// port and one synchronous write port.
//   clk, reset            : clock, async active-high reset (invalidates all)
//   rd_pc                 : lookup PC
//   rd_hit/target/jump    : lookup result
//   wr_en/pc/target/jump  : allocate/overwrite the line indexed by wr_pc
module ucsbece154b_btb
   import ucsbece154b_bp_pkg::*;
#(
   parameter int NUM_ENTRIES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] rd_pc,
   output logic        rd_hit,
   output logic [31:0] rd_target,
   output logic        rd_jump,
   input  logic        wr_en,
   input  logic [31:0] wr_pc,
   input  logic [31:0] wr_target,
   input  logic        wr_jump
);

   localparam int BI = $clog2(NUM_ENTRIES);

   btb_entry_t       mem [NUM_ENTRIES];
   btb_entry_t       rd_entry;
   logic [BI-1:0]    rd_idx;
   logic [BI-1:0]    wr_idx;
   logic             unused_pc_bits;

   assign rd_idx    = rd_pc[BI+1:2];
   assign wr_idx    = wr_pc[BI+1:2];
   assign rd_entry  = mem[rd_idx];
   assign rd_hit    = rd_entry.valid && (rd_entry.tag == TAG_MAX'(rd_pc[31:BI+2]));
   assign rd_target = rd_entry.target;
   assign rd_jump   = rd_entry.jump;

   // Instructions are word aligned; the byte offset never selects anything.
   assign unused_pc_bits = ^{rd_pc[1:0], wr_pc[1:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_ENTRIES; i++)
            mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_idx] <= '{valid:  1'b1,
                          jump:   wr_jump,
                          tag:    TAG_MAX'(wr_pc[31:BI+2]),
                          target: wr_target};
      end
   end

endmodule

// File: rtl/ucsbece154b_gshare_bp.sv
// Gshare branch predictor: BTB + 2-bit PHT indexed by pc[G+1:2] ^ GHR.
// Predicts combinationally in Fetch, trains and repairs from Execute.
//   Fetch   : stall_f_i, pc_f_i, op_f_i -> predict_taken_f_o,
//             predict_target_f_o, phtidx_f_o, ghr_f_o (snapshot for E)
//   Execute : resolve_e_i, branch_e_i, jump_e_i, taken_e_i, pc_e_i,
//             target_e_i, phtidx_e_i, ghr_e_i, mispredict_e_i
//   Stats   : stat_branches_o, stat_mispredicts_o (wrap at 2^32)
module ucsbece154b_gshare_bp
   import ucsbece154b_bp_pkg::*;
#(
   parameter int NUM_BTB_ENTRIES = 32,
   parameter int NUM_GHR_BITS    = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    stall_f_i,
   input  logic [31:0]             pc_f_i,
   input  logic [6:0]              op_f_i,
   output logic                    predict_taken_f_o,
   output logic [31:0]             predict_target_f_o,
   output logic [NUM_GHR_BITS-1:0] phtidx_f_o,
   output logic [NUM_GHR_BITS-1:0] ghr_f_o,
   input  logic                    resolve_e_i,
   input  logic                    branch_e_i,
   input  logic                    jump_e_i,
   input  logic                    taken_e_i,
   input  logic [31:0]             pc_e_i,
   input  logic [31:0]             target_e_i,
   input  logic [NUM_GHR_BITS-1:0] phtidx_e_i,
   input  logic [NUM_GHR_BITS-1:0] ghr_e_i,
   input  logic                    mispredict_e_i,
   output logic [31:0]             stat_branches_o,
   output logic [31:0]             stat_mispredicts_o
);

   localparam int G     = NUM_GHR_BITS;
   localparam int PHT_N = 1 << G;

   logic [G-1:0] ghr;
   logic [G-1:0] ghr_next;
   ctr_t         pht [PHT_N];
   logic         btb_hit;
   logic         btb_jump;
   logic [31:0]  btb_target;
   logic         is_branch_f;
   logic         is_ctl_f;

   assign is_branch_f = (op_f_i == OP_BRANCH);
   assign is_ctl_f    = is_branch_f || (op_f_i == OP_JAL);

   assign phtidx_f_o         = pc_f_i[G+1:2] ^ ghr;
   assign ghr_f_o            = ghr;
   assign predict_taken_f_o  = is_ctl_f & btb_hit & (btb_jump | pht[phtidx_f_o][1]);
   assign predict_target_f_o = btb_target;

   ucsbece154b_btb #(
      .NUM_ENTRIES (NUM_BTB_ENTRIES)
   ) u_btb (
      .clk       (clk),
      .reset     (reset),
      .rd_pc     (pc_f_i),
      .rd_hit    (btb_hit),
      .rd_target (btb_target),
      .rd_jump   (btb_jump),
      .wr_en     (resolve_e_i & taken_e_i),
      .wr_pc     (pc_e_i),
      .wr_target (target_e_i),
      .wr_jump   (jump_e_i)
   );

   // Repair is assigned last so it wins over a same-cycle speculative shift.
   always_comb begin
      ghr_next = ghr;
      if (!stall_f_i && is_branch_f)
         ghr_next = {ghr[G-2:0], predict_taken_f_o};
      if (resolve_e_i && mispredict_e_i) begin
         if (branch_e_i)
            ghr_next = {ghr_e_i[G-2:0], taken_e_i};
         else
            ghr_next = ghr_e_i;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ghr <= '0;
      else
         ghr <= ghr_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < PHT_N; i++)
            pht[i] <= WNT;
      end else if (resolve_e_i && branch_e_i) begin
         pht[phtidx_e_i] <= ctr_next(pht[phtidx_e_i], taken_e_i);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_branches_o    <= '0;
         stat_mispredicts_o <= '0;
      end else if (resolve_e_i) begin
         stat_branches_o <= stat_branches_o + 32'd1;
         if (mispredict_e_i)
            stat_mispredicts_o <= stat_mispredicts_o + 32'd1;
      end
   end

endmodule
